tx_frame_scheduler: RTL and testbench
=====================================

Name: tx_frame_scheduler

Overview:
- Sits in front of the serial `tx` block and shares it between two frame requesters: A (board-state frames) and B (move/ack frames).
- Latches the granted 208-bit payload onto `tx`'s `val_in` and drives `tx`'s `trigger_in` as a timed pulse.
- `tx` reports no completion, so the block enforces a fixed frame-time guard and an inter-frame gap before the next grant.
- Clocked at the 100 MHz system clock.

Parameters:
- WIDTH, 208, payload width; matches `tx` `val_in`.
- TRIG_CYCLES, 1000, trigger_out high time in cycles; must be >= 1.
- FRAME_CYCLES, 4000000, guard cycles after trigger falls, covering serialisation of one frame; 0 allowed (state skipped).
- GAP_CYCLES, 1000, idle gap after the guard before the next grant; 0 allowed (state skipped).
- HB_CYCLES, 50000000, idle cycles before a heartbeat resend (only with HEARTBEAT_EN).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- req_a_in  input  1  requester A frame request; held until ack_a_out.
- val_a_in  input  WIDTH  requester A payload; stable while req_a_in is high.
- ack_a_out  output  1  one-cycle pulse; A payload captured this cycle.
- req_b_in  input  1  requester B frame request.
- val_b_in  input  WIDTH  requester B payload.
- ack_b_out  output  1  one-cycle pulse; B payload captured.
- trigger_out  output  1  to `tx` `trigger_in`.
- val_out  output  WIDTH  to `tx` `val_in`; held between loads.
- busy_out  output  1  high whenever state != IDLE.
- frames_sent_out  output  16  count of frames started; wraps 0xFFFF->0.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; round-robin pointer = "A next"; counters 0.
- Reset mid-frame: next edge forces trigger_out=0, busy_out=0, val_out=0. No ack is pending afterwards.
- States: IDLE -> TRIG -> WAIT -> GAP -> IDLE.
- IDLE
  - Arbitration happens only here, on the registered inputs of each edge.
  - If exactly one req is high, that requester is granted.
  - If both are high, the requester pointed to by the RR pointer is granted; the pointer then flips to the other requester.
  - A single grant also sets the pointer to the non-granted requester.
- Grant edge:
  - Next cycle: ack_x_out=1 (exactly one cycle), val_out <= val_x_in, trigger_out=1, state=TRIG, frames_sent_out+1.
  - The ack cycle is TRIG cycle 1.
- TRIG: trigger_out high for exactly TRIG_CYCLES cycles, then WAIT.
- WAIT: FRAME_CYCLES cycles with trigger_out=0, then GAP.
- GAP: GAP_CYCLES cycles, then IDLE.
- busy_out=1 from the ack cycle through the last GAP cycle.
- Minimum ack-to-ack spacing is TRIG_CYCLES+FRAME_CYCLES+GAP_CYCLES+1 cycles, because one IDLE cycle always samples.
- Requests outside IDLE: ignored until IDLE, never lost while held. A req dropped before its ack has no effect.
- Both acks are never high in the same cycle.
- val_out changes only on a grant edge (or heartbeat reload, see below) and is stable for the whole frame.

Optional Feature:
- Macro: TX_FRAME_SCHEDULER_HEARTBEAT_EN.
- Defined:
  - An idle counter increments each IDLE cycle with no req and clears on any grant or req.
  - When it reaches HB_CYCLES, and at least one frame has been sent since reset, the block re-enters TRIG with val_out unchanged.
  - No ack is issued; frames_sent_out increments.
  - A req present in the same cycle takes priority and clears the counter.
- Undefined: no idle counter; the block stays in IDLE indefinitely without requests.

Test Plan:
Bench uses TRIG_CYCLES=2, FRAME_CYCLES=10, GAP_CYCLES=3, HB_CYCLES=20.
- Reset then idle 50 cycles -> all outputs 0, busy_out=0; no heartbeat, since no frame has been sent yet.
- req_a_in=1 with val_a_in=208'hAAAA…AAAA, sampled at edge N:
  - Edge N+1: ack_a_out pulse, val_out=208'hAAAA…AAAA.
  - trigger_out high for cycles N+1..N+2; busy_out high for 15 cycles; frames_sent_out=1.
- req_a and req_b both held from reset -> grants A, B, A, B; acks 16 cycles apart; each val_out matches its requester.
- req_b pulsed for 1 cycle during WAIT and dropped -> no ack_b_out, no new frame.
- rst_in asserted in TRIG cycle 2 -> next cycle trigger_out=0, busy_out=0, val_out=0, frames_sent_out=0. A later req_a is granted normally.
- With TX_FRAME_SCHEDULER_HEARTBEAT_EN, after one A frame and 20 idle cycles:
  - trigger_out reasserts with the same val_out, no ack pulse, frames_sent_out=2.
  - Without the macro: no resend.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: shares the serial tx block between frame requesters
// A (board-state) and B (move/ack) with round-robin arbitration.
// It latches the granted payload onto val_out, pulses trigger_out for
// TRIG_CYCLES, then holds off FRAME_CYCLES + GAP_CYCLES before the next
// grant, because tx gives no completion indication.
//
// Ports:
//   clk_in, rst_in           system clock, synchronous active-high reset
//   req_a_in, val_a_in       requester A request (held until ack) + payload
//   ack_a_out                one-cycle pulse, A payload captured
//   req_b_in, val_b_in       requester B request + payload
//   ack_b_out                one-cycle pulse, B payload captured
//   trigger_out, val_out     to tx trigger_in / val_in
//   busy_out                 high whenever the scheduler is not IDLE
//   frames_sent_out          count of frames started (wraps)
//
// Optional build macro TX_FRAME_SCHEDULER_HEARTBEAT_EN: after HB_CYCLES
// request-free IDLE cycles, resend the last payload (no ack issued).
module tx_frame_scheduler #(
    parameter int WIDTH        = 208,
    parameter int TRIG_CYCLES  = 1000,
    parameter int FRAME_CYCLES = 4000000,
    parameter int GAP_CYCLES   = 1000,
    parameter int HB_CYCLES    = 50000000
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req_a_in,
    input  logic [WIDTH-1:0] val_a_in,
    output logic             ack_a_out,
    input  logic             req_b_in,
    input  logic [WIDTH-1:0] val_b_in,
    output logic             ack_b_out,
    output logic             trigger_out,
    output logic [WIDTH-1:0] val_out,
    output logic             busy_out,
    output logic [15:0]      frames_sent_out
);

    if (TRIG_CYCLES < 1 || FRAME_CYCLES < 0 || GAP_CYCLES < 0 ||
        HB_CYCLES < 1) begin : g_bad_params
        $error("tx_frame_scheduler: illegal cycle parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT,
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;
    // 0: A wins the next tie, 1: B wins the next tie
    logic               rr_q, rr_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic               trig_q, trig_d;
    logic               busy_q, busy_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic [15:0]        frames_q, frames_d;

    logic               grant_a;
    logic               grant_b;
    logic               start;

`ifdef TX_FRAME_SCHEDULER_HEARTBEAT_EN
    localparam int HB_W = $clog2(HB_CYCLES + 1);

    logic [HB_W-1:0]    idle_q, idle_d;
    // frames_q may wrap to 0, so "sent since reset" needs its own flag
    logic               sent_q, sent_d;
    logic               hb_fire;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        val_d    = val_q;
        frames_d = frames_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        start    = 1'b0;
`ifdef TX_FRAME_SCHEDULER_HEARTBEAT_EN
        idle_d   = '0;
        sent_d   = sent_q;
        hb_fire  = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_a_in && (!req_b_in || !rr_q)) begin
                    grant_a = 1'b1;
                end else if (req_b_in) begin
                    grant_b = 1'b1;
                end
`ifdef TX_FRAME_SCHEDULER_HEARTBEAT_EN
                else if (sent_q) begin
                    // idle_q counts completed request-free IDLE cycles
                    if (idle_q == HB_W'(HB_CYCLES - 1)) begin
                        hb_fire = 1'b1;
                    end else begin
                        idle_d = idle_q + HB_W'(1);
                    end
                end
                if (grant_a || grant_b) begin
                    sent_d = 1'b1;
                end
                start = grant_a | grant_b | hb_fire;
`else
                start = grant_a | grant_b;
`endif
                if (start) begin
                    state_d  = S_TRIG;
                    cnt_d    = '0;
                    frames_d = frames_q + 16'd1;
                end
                if (grant_a) begin
                    val_d   = val_a_in;
                    ack_a_d = 1'b1;
                    rr_d    = 1'b1;
                end
                if (grant_b) begin
                    val_d   = val_b_in;
                    ack_b_d = 1'b1;
                    rr_d    = 1'b0;
                end
            end

            S_TRIG: begin
                if (cnt_q == 32'(TRIG_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (FRAME_CYCLES > 0) begin
                        state_d = S_WAIT;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_WAIT: begin
                if (cnt_q == 32'(FRAME_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_GAP: begin
                if (cnt_q == 32'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered copies of the next state, so they line
        // up with the state they describe.
        trig_d = (state_d == S_TRIG);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rr_q     <= 1'b0;
            val_q    <= '0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            frames_q <= '0;
`ifdef TX_FRAME_SCHEDULER_HEARTBEAT_EN
            idle_q   <= '0;
            sent_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            val_q    <= val_d;
            trig_q   <= trig_d;
            busy_q   <= busy_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            frames_q <= frames_d;
`ifdef TX_FRAME_SCHEDULER_HEARTBEAT_EN
            idle_q   <= idle_d;
            sent_q   <= sent_d;
`endif
        end
    end

    assign ack_a_out       = ack_a_q;
    assign ack_b_out       = ack_b_q;
    assign trigger_out     = trig_q;
    assign val_out         = val_q;
    assign busy_out        = busy_q;
    assign frames_sent_out = frames_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler: cycle vector table plus
// directed sequences for round-robin, pointer and heartbeat behaviour.
module tb_tx_frame_scheduler;

    localparam int W     = 208;
    localparam int TRIG  = 2;
    localparam int FRAME = 10;
    localparam int GAP   = 3;
    localparam int HB    = 20;
    localparam int SPAN  = TRIG + FRAME + GAP + 1;

    localparam logic [W-1:0] PA = {13{16'hAAAA}};
    localparam logic [W-1:0] PB = {13{16'h5B5B}};
    localparam logic [W-1:0] PC = {13{16'hC3C3}};
    localparam logic [W-1:0] PD = {13{16'hD00D}};
    localparam logic [W-1:0] PE = {13{16'hE1E1}};

    logic          clk = 1'b0;
    logic          rst;
    logic          req_a;
    logic [W-1:0]  val_a;
    logic          ack_a;
    logic          req_b;
    logic [W-1:0]  val_b;
    logic          ack_b;
    logic          trig;
    logic [W-1:0]  val_o;
    logic          busy;
    logic [15:0]   frames;

    always #5 clk = ~clk;

    tx_frame_scheduler #(
        .WIDTH        (W),
        .TRIG_CYCLES  (TRIG),
        .FRAME_CYCLES (FRAME),
        .GAP_CYCLES   (GAP),
        .HB_CYCLES    (HB)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .req_a_in        (req_a),
        .val_a_in        (val_a),
        .ack_a_out       (ack_a),
        .req_b_in        (req_b),
        .val_b_in        (val_b),
        .ack_b_out       (ack_b),
        .trigger_out     (trig),
        .val_out         (val_o),
        .busy_out        (busy),
        .frames_sent_out (frames)
    );

    typedef struct {
        logic          rst;
        logic          ra;
        logic          rb;
        logic [W-1:0]  va;
        logic [W-1:0]  vb;
        logic          eaa;
        logic          eab;
        logic          etr;
        logic          ebz;
        logic [15:0]   efr;
        logic [W-1:0]  evo;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r, input logic ra, input logic rb,
                       input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic eaa, input logic eab, input logic etr,
                       input logic ebz, input logic [15:0] efr,
                       input logic [W-1:0] evo);
        vec_t v;
        v.rst = r;   v.ra = ra;   v.rb = rb;   v.va = va;  v.vb = vb;
        v.eaa = eaa; v.eab = eab; v.etr = etr; v.ebz = ebz;
        v.efr = efr; v.evo = evo;
        vecs.push_back(v);
    endtask

    // Rest of a frame after its ack cycle: TRIG 2, WAIT, GAP, then idles.
    task automatic add_tail(input logic [15:0] f, input logic [W-1:0] v,
                            input int idles);
        add(0, 0, 0, '0, '0, 0, 0, 1, 1, f, v);
        for (int i = 0; i < FRAME + GAP; i++)
            add(0, 0, 0, '0, '0, 0, 0, 0, 1, f, v);
        for (int i = 0; i < idles; i++)
            add(0, 0, 0, '0, '0, 0, 0, 0, 0, f, v);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        val_a = '0; val_b = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ack_t[$];
        logic [W-1:0] ack_v[$];
        logic ack_w[$];
        logic [15:0] ack_f[$];
        int cyc;
        int rise_t;
        logic prev_trig;

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        val_a = '0; val_b = '0;
        @(negedge clk);

        // ---- vector table ----
        add(1, 0, 0, '0, '0, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 50; i++)
            add(0, 0, 0, '0, '0, 0, 0, 0, 0, 0, '0);
        // A frame; B pulses one cycle during WAIT and must be ignored
        add(0, 1, 0, PA, '0, 1, 0, 1, 1, 1, PA);
        add(0, 0, 0, '0, '0, 0, 0, 1, 1, 1, PA);
        for (int i = 0; i < FRAME + GAP; i++) begin
            if (i == 3) add(0, 0, 1, '0, PB, 0, 0, 0, 1, 1, PA);
            else        add(0, 0, 0, '0, '0, 0, 0, 0, 1, 1, PA);
        end
        for (int i = 0; i < 3; i++)
            add(0, 0, 0, '0, '0, 0, 0, 0, 0, 1, PA);
        // A frame reset during TRIG cycle 2
        add(0, 1, 0, PC, '0, 1, 0, 1, 1, 2, PC);
        add(1, 0, 0, '0, '0, 0, 0, 0, 0, 0, '0);
        add(0, 0, 0, '0, '0, 0, 0, 0, 0, 0, '0);
        add(0, 0, 0, '0, '0, 0, 0, 0, 0, 0, '0);
        // later A request is served normally
        add(0, 1, 0, PD, '0, 1, 0, 1, 1, 1, PD);
        add_tail(1, PD, 2);
        // single B request
        add(0, 0, 1, '0, PB, 0, 1, 1, 1, 2, PB);
        add_tail(2, PB, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; req_a = vecs[i].ra; req_b = vecs[i].rb;
            val_a = vecs[i].va; val_b = vecs[i].vb;
            tick();
            checks++;
            if ({ack_a, ack_b, trig, busy, frames, val_o} !==
                {vecs[i].eaa, vecs[i].eab, vecs[i].etr, vecs[i].ebz,
                 vecs[i].efr, vecs[i].evo}) begin
                errors++;
                $display("FAIL vec%0d: ack_a=%0b ack_b=%0b trig=%0b busy=%0b fr=%0d val=%h want %0b %0b %0b %0b %0d %h",
                         i, ack_a, ack_b, trig, busy, frames, val_o,
                         vecs[i].eaa, vecs[i].eab, vecs[i].etr,
                         vecs[i].ebz, vecs[i].efr, vecs[i].evo);
            end
        end

        // ---- both requesters held from reset: A,B,A,B ----
        do_reset();
        req_a = 1'b1; val_a = PA;
        req_b = 1'b1; val_b = PB;
        cyc = 0;
        while (ack_t.size() < 4 && cyc < 120) begin
            tick();
            cyc++;
            if (ack_a && ack_b) chk("both_acks", 1, 0);
            if (ack_a || ack_b) begin
                ack_t.push_back(cyc);
                ack_w.push_back(ack_b);
                ack_v.push_back(val_o);
                ack_f.push_back(frames);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        chk("rr_ack_count", ack_t.size(), 4);
        for (int k = 0; k < ack_t.size(); k++) begin
            chk($sformatf("rr_who%0d", k), ack_w[k], k % 2);
            chk($sformatf("rr_val%0d", k), ack_v[k], (k % 2) ? PB : PA);
            chk($sformatf("rr_frames%0d", k), ack_f[k], k + 1);
            if (k > 0)
                chk($sformatf("rr_spacing%0d", k),
                    ack_t[k] - ack_t[k-1], SPAN);
        end

        // ---- single A grant points the tie-break at B ----
        do_reset();
        req_a = 1'b1; val_a = PC;
        tick();
        chk("ptr_first_ack_a", ack_a, 1);
        req_a = 1'b0;
        cyc = 0;
        while (busy && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("ptr_busy_drop", busy, 0);
        req_a = 1'b1; val_a = PA;
        req_b = 1'b1; val_b = PB;
        tick();
        chk("ptr_tie_ack_b", {ack_a, ack_b}, 2'b01);
        chk("ptr_tie_val", val_o, PB);
        req_a = 1'b0; req_b = 1'b0;

        // ---- heartbeat after one A frame ----
        do_reset();
        req_a = 1'b1; val_a = PE;
        tick();
        chk("hb_ack", ack_a, 1);
        req_a = 1'b0; val_a = '0;
        rise_t = -1;
        prev_trig = trig;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (ack_a || ack_b) chk($sformatf("hb_no_ack_t%0d", t), 1, 0);
            if (trig && !prev_trig && rise_t < 0) begin
                rise_t = t;
                chk("hb_val_same", val_o, PE);
                chk("hb_frames", frames, 2);
                chk("hb_busy", busy, 1);
            end
            prev_trig = trig;
        end
`ifdef TX_FRAME_SCHEDULER_HEARTBEAT_EN
        chk("hb_rise_cycle", rise_t, SPAN - 1 + HB);
`else
        chk("hb_no_resend", rise_t, -1);
        chk("hb_frames_idle", frames, 1);
        chk("hb_idle_busy", busy, 0);
        chk("hb_val_held", val_o, PE);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
